// File: rtl/data_path.sv
// Purpose: 32-bit register-file datapath with a single shared bus, a combinational ALU and a 64-bit Z result register.
// Latency: the bus and the ALU are combinational, and registers load on the rising Clock edge, so Z captures the result on the same edge the operands are on the bus.
// Backpressure: none; the enables are obeyed on every edge, and clear (async, active-high) zeroes all state and blocks loads.
// Optional feature: define DATA_PATH_MULDIV_EN to implement MUL/DIV; otherwise those opcodes yield 0.
module data_path (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Read,
  input  logic [4:0]  op,
  input  logic [31:0] Mdatain,
  input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic        HIOut,
  input  logic        LOout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        InPortout,
  input  logic        Yout,
  input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
  input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
  input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
  input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
  input  logic        HIin,
  input  logic        Loin,
  input  logic        ZHighin,
  input  logic        Zlowin,
  input  logic        InPC,
  input  logic        MDRin,
  input  logic        InPortin,
  input  logic        Yin,
  output logic [31:0] BusOut,
  output logic [31:0] mdrData,
  output logic [31:0] BusMuxInR0,
  output logic [31:0] BusMuxInR1,
  output logic [31:0] BusMuxInR2,
  output logic [31:0] BusMuxInYOut
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;

  logic [31:0] r_q [16];
  logic [31:0] hi_q, lo_q, zhi_q, zlo_q, pc_q, mdr_q, inport_q, y_q;
  logic [31:0] zhi_d, zlo_d, mdr_d;

  logic [15:0] r_out, r_in;
  logic [23:0] src_en;
  logic [31:0] src_val [24];
  logic [31:0] bus;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

  // Source enables in bus priority order: index 0 wins.
  assign src_en = {Yout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIOut, r_out};

  // Present every bus source's value at its priority index.
  always_comb begin
    for (int i = 0; i < 16; i++) src_val[i] = r_q[i];
    src_val[16] = hi_q;
    src_val[17] = lo_q;
    src_val[18] = zhi_q;
    src_val[19] = zlo_q;
    src_val[20] = pc_q;
    src_val[21] = mdr_q;
    src_val[22] = inport_q;
    src_val[23] = y_q;
  end

  // Priority bus mux: scan from lowest priority up so the lowest asserted index is what remains.
  always_comb begin
    bus = '0;
    for (int i = 23; i >= 0; i--) begin
      if (src_en[i]) bus = src_val[i];
    end
  end

  // ALU operands: A comes from Y, B is whatever is on the bus this cycle.
  logic [31:0]        alu_a, alu_b;
  logic signed [31:0] alu_a_s, alu_b_s;
  logic [4:0]         sh;
  logic [63:0]        rot_r, rot_l;
  logic [63:0]        alu_r;

  assign alu_a   = y_q;
  assign alu_b   = bus;
  assign alu_a_s = alu_a;
  assign alu_b_s = alu_b;
  assign sh      = alu_b[4:0];
  // Rotates via a doubled operand: the wrapped-around bits fall into the kept half.
  assign rot_r   = {alu_a, alu_a} >> sh;
  assign rot_l   = {alu_a, alu_a} << sh;

`ifdef DATA_PATH_MULDIV_EN
  logic signed [63:0] prod;
  logic signed [31:0] quo, rem;
  assign prod = alu_a_s * alu_b_s;
  assign quo  = (alu_b == '0) ? '0 : alu_a_s / alu_b_s;
  assign rem  = (alu_b == '0) ? '0 : alu_a_s % alu_b_s;
`endif

  // Combinational ALU; only MUL/DIV use the upper half of the result.
  always_comb begin
    alu_r = '0;
    case (op)
      OP_ADD:  alu_r[31:0] = alu_a + alu_b;
      OP_SUB:  alu_r[31:0] = alu_a - alu_b;
      OP_AND:  alu_r[31:0] = alu_a & alu_b;
      OP_OR:   alu_r[31:0] = alu_a | alu_b;
      OP_SHR:  alu_r[31:0] = alu_a >> sh;
      OP_SHRA: alu_r[31:0] = alu_a_s >>> sh;
      OP_SHL:  alu_r[31:0] = alu_a << sh;
      OP_ROR:  alu_r[31:0] = rot_r[31:0];
      OP_ROL:  alu_r[31:0] = rot_l[63:32];
`ifdef DATA_PATH_MULDIV_EN
      OP_MUL:  alu_r       = prod;
      OP_DIV:  alu_r       = {rem, quo};
`else
      OP_MUL:  alu_r       = '0;
      OP_DIV:  alu_r       = '0;
`endif
      OP_NEG:  alu_r[31:0] = -alu_b;
      OP_NOT:  alu_r[31:0] = ~alu_b;
      default: alu_r       = '0;
    endcase
  end

  // Next-state values for the registers that do not load straight from the bus.
  always_comb begin
    zhi_d = alu_r[63:32];
    zlo_d = alu_r[31:0];
    mdr_d = Read ? Mdatain : bus;
  end

  // Register file and special registers; clear zeroes everything without waiting for a clock.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zhi_q    <= '0;
      zlo_q    <= '0;
      pc_q     <= '0;
      mdr_q    <= '0;
      inport_q <= '0;
      y_q      <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r_in[i]) r_q[i] <= bus;
      end
      if (HIin)     hi_q     <= bus;
      if (Loin)     lo_q     <= bus;
      if (ZHighin)  zhi_q    <= zhi_d;
      if (Zlowin)   zlo_q    <= zlo_d;
      if (InPC)     pc_q     <= bus;
      if (MDRin)    mdr_q    <= mdr_d;
      if (InPortin) inport_q <= bus;
      if (Yin)      y_q      <= bus;
    end
  end

  assign BusOut       = bus;
  assign mdrData      = mdr_q;
  assign BusMuxInR0   = r_q[0];
  assign BusMuxInR1   = r_q[1];
  assign BusMuxInR2   = r_q[2];
  assign BusMuxInYOut = y_q;

endmodule

// File: tb/tb_data_path.sv
// Directed-vector bench for data_path: register moves through MDR, ALU ops via Y/R2 into Z, bus priority, clear behaviour.
// Inputs change 1 time unit after the rising edge; outputs are sampled there or mid-cycle.
// Expected values are hand-computed constants; MUL/DIV expectations follow DATA_PATH_MULDIV_EN.
module tb_data_path;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic        Read  = 1'b0;
  logic [4:0]  op    = '0;
  logic [31:0] Mdatain = '0;
  logic [15:0] rout = '0;
  logic [15:0] rin  = '0;
  logic [7:0]  sout = '0;
  logic [7:0]  sin  = '0;
  logic [31:0] bus_o, mdr_o, r0_o, r1_o, r2_o, y_o;

  int checks = 0;
  int errors = 0;

  // Special source enables (sout) and load enables (sin) bit positions.
  localparam logic [7:0] SO_HI = 8'h01, SO_LO = 8'h02, SO_ZH = 8'h04, SO_ZL = 8'h08;
  localparam logic [7:0] SO_PC = 8'h10, SO_MDR = 8'h20, SO_IN = 8'h40, SO_Y = 8'h80;
  localparam logic [7:0] SI_HI = 8'h01, SI_LO = 8'h02, SI_ZH = 8'h04, SI_ZL = 8'h08;
  localparam logic [7:0] SI_PC = 8'h10, SI_MDR = 8'h20, SI_IN = 8'h40, SI_Y = 8'h80;

  always #5 Clock = ~Clock;

  data_path dut (
    .Clock(Clock), .clear(clear), .Read(Read), .op(op), .Mdatain(Mdatain),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIOut(sout[0]), .LOout(sout[1]), .Zhighout(sout[2]), .Zlowout(sout[3]),
    .PCout(sout[4]), .MDRout(sout[5]), .InPortout(sout[6]), .Yout(sout[7]),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(sin[0]), .Loin(sin[1]), .ZHighin(sin[2]), .Zlowin(sin[3]),
    .InPC(sin[4]), .MDRin(sin[5]), .InPortin(sin[6]), .Yin(sin[7]),
    .BusOut(bus_o), .mdrData(mdr_o), .BusMuxInR0(r0_o), .BusMuxInR1(r1_o),
    .BusMuxInR2(r2_o), .BusMuxInYOut(y_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bus cycle: assert enables, take the edge, release enables just after it.
  task automatic cyc(input logic [15:0] ro, input logic [7:0] so, input logic [15:0] ri, input logic [7:0] si);
    rout = ro; sout = so; rin = ri; sin = si;
    @(posedge Clock);
    #1;
    rout = '0; sout = '0; rin = '0; sin = '0;
  endtask

  // Bring a constant in through MDR, then move it to the selected registers.
  task automatic load_reg(input logic [15:0] ri, input logic [7:0] si, input logic [31:0] v);
    Mdatain = v; Read = 1'b1;
    cyc('0, '0, '0, SI_MDR);
    Read = 1'b0;
    cyc('0, SO_MDR, ri, si);
  endtask

  // Y=a, R2=b, run opcode into Z, then Zlow->R1 and Zhigh->R0 for observation.
  task automatic alu_chk(input string tag, input logic [4:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    load_reg('0, SI_Y, a);
    load_reg(16'h0004, '0, b);
    op = o;
    cyc(16'h0004, '0, '0, SI_ZH | SI_ZL);
    cyc('0, SO_ZL, 16'h0002, '0);
    cyc('0, SO_ZH, 16'h0001, '0);
    check_val({tag, "_lo"}, r1_o, exp_lo);
    check_val({tag, "_hi"}, r0_o, exp_hi);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_bus"}, bus_o, '0);
    check_val({tag, "_mdr"}, mdr_o, '0);
    check_val({tag, "_r0"},  r0_o,  '0);
    check_val({tag, "_r1"},  r1_o,  '0);
    check_val({tag, "_r2"},  r2_o,  '0);
    check_val({tag, "_y"},   y_o,   '0);
  endtask

  initial begin
    // Reset state, released between edges.
    #12;
    check_all_zero("rst");
    clear = 1'b0;
    @(posedge Clock);
    #1;

    // SHRA of -12 by 5.
    Mdatain = 32'hFFFF_FFF4; Read = 1'b1;
    cyc('0, '0, '0, SI_MDR);
    Read = 1'b0;
    cyc('0, SO_MDR, '0, SI_Y);
    load_reg(16'h0004, '0, 32'd5);
    op = 5'b00101;
    cyc(16'h0004, '0, '0, SI_ZH | SI_ZL);
    cyc('0, SO_ZL, 16'h0002, '0);
    cyc('0, SO_ZH, 16'h0001, '0);
    check_val("shra_y",  y_o,  32'hFFFF_FFF4);
    check_val("shra_r2", r2_o, 32'd5);
    check_val("shra_r1", r1_o, 32'hFFFF_FFFF);
    check_val("shra_r0", r0_o, 32'h0);

    // Remaining ALU operations.
    alu_chk("add",    5'b00000, 32'd3,          32'd4,          32'h0, 32'd7);
    alu_chk("sub",    5'b00001, 32'd0,          32'd1,          32'h0, 32'hFFFF_FFFF);
    alu_chk("addwrap",5'b00000, 32'hFFFF_FFFF,  32'd2,          32'h0, 32'd1);
    alu_chk("and",    5'b00010, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h0, 32'h00F0_1234);
    alu_chk("or",     5'b00011, 32'hF000_0000,  32'h0000_000F,  32'h0, 32'hF000_000F);
    alu_chk("shr",    5'b00100, 32'h8000_0000,  32'd4,          32'h0, 32'h0800_0000);
    alu_chk("shl",    5'b00110, 32'h0000_0001,  32'd31,         32'h0, 32'h8000_0000);
    alu_chk("ror",    5'b00111, 32'h0000_0001,  32'd1,          32'h0, 32'h8000_0000);
    alu_chk("rol",    5'b01000, 32'h8000_0001,  32'd4,          32'h0, 32'h0000_0018);
    alu_chk("neg",    5'b01011, 32'd0,          32'd5,          32'h0, 32'hFFFF_FFFB);
    alu_chk("not",    5'b01100, 32'd0,          32'h0F0F_0F0F,  32'h0, 32'hF0F0_F0F0);
    alu_chk("unused", 5'b01101, 32'd3,          32'd4,          32'h0, 32'h0);
`ifdef DATA_PATH_MULDIV_EN
    alu_chk("mul",    5'b01001, 32'h0001_0000,  32'h0001_0000,  32'h1, 32'h0);
    alu_chk("div",    5'b01010, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
    alu_chk("mul",    5'b01001, 32'h0001_0000,  32'h0001_0000,  32'h0, 32'h0);
    alu_chk("div",    5'b01010, 32'hFFFF_FFF9,  32'd2,          32'h0, 32'h0);
`endif
    alu_chk("div0",   5'b01010, 32'hFFFF_FFF9,  32'd0,          32'h0, 32'h0);

    // Bus priority: R1 beats MDR; nothing asserted gives 0.
    load_reg(16'h0002, '0, 32'hAAAA_5555);
    Mdatain = 32'h1357_9BDF; Read = 1'b1;
    cyc('0, '0, '0, SI_MDR);
    Read = 1'b0;
    rout = 16'h0002; sout = SO_MDR;
    #1;
    check_val("prio_r1", bus_o, 32'hAAAA_5555);
    rout = '0; sout = '0;
    #1;
    check_val("prio_none", bus_o, 32'h0);

    // MDR loads from the bus when Read is low.
    load_reg(16'h0004, '0, 32'h1234_5678);
    Read = 1'b0;
    cyc(16'h0004, '0, '0, SI_MDR);
    check_val("mdr_bus", mdr_o, 32'h1234_5678);

    // Clear held across an edge discards the pending MDR load.
    Read = 1'b1; Mdatain = 32'hDEAD_BEEF;
    rout = 16'h0004; sin = SI_MDR;
    #2;
    clear = 1'b1;
    @(posedge Clock);
    #1;
    check_val("mdr_clr", mdr_o, 32'h0);
    check_val("mdr_clr_r2", r2_o, 32'h0);
    clear = 1'b0; rout = '0; sin = '0; Read = 1'b0;
    @(posedge Clock);
    #1;

    // Clear pulsed between edges zeroes outputs with no clock edge.
    load_reg(16'h0007, SI_Y, 32'hCAFE_F00D);
    check_val("pre_clr_r1", r1_o, 32'hCAFE_F00D);
    #1;
    clear = 1'b1;
    #2;
    clear = 1'b0;
    #1;
    check_all_zero("midclr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
